// File: rtl/eink_seq_ctrl.sv
// SSD1680-class e-paper refresh sequencer: panel reset, setup, pixel stream, update, sleep.
// Bytes go out through an external SPI master via a write/wait/stream handshake.
module eink_seq_ctrl #(
   parameter int X_BYTES       = 16,
   parameter int Y_LINES       = 250,
   parameter int RST_CYCLES    = 500000,
   parameter int SETTLE_CYCLES = 500000,
   parameter int BUSY_TIMEOUT  = 16777215,
   parameter int STRIPE_BIT    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] mode,
   input  logic [7:0] pix_data,
   input  logic       pix_valid,
   output logic       pix_ready,
   output logic [7:0] spi_data,
   output logic       spi_we,
   input  logic       spi_wait,
   output logic       spi_stream,
   output logic       dc,
   output logic       epd_resetb,
   input  logic       epd_busy,
   output logic       active,
   output logic       done,
   output logic       error
);

   localparam int TOTAL = X_BYTES * Y_LINES;
   localparam int PW0   = $clog2(TOTAL + 1);
   localparam int PW    = (PW0 > STRIPE_BIT) ? PW0 : STRIPE_BIT + 1;
   localparam int DMAX0 = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
   localparam int DMAX  = (DMAX0 > BUSY_TIMEOUT) ? DMAX0 : BUSY_TIMEOUT;
   localparam int DW    = $clog2(DMAX + 1);

   localparam logic [PW-1:0] P_LAST      = PW'(TOTAL - 1);
   localparam logic [DW-1:0] RST_LAST    = DW'(RST_CYCLES - 1);
   localparam logic [DW-1:0] SETTLE_LAST = DW'(SETTLE_CYCLES - 1);
   localparam logic [DW-1:0] BUSY_LAST   = DW'(BUSY_TIMEOUT - 1);
   localparam logic [7:0]    XM1         = 8'(X_BYTES - 1);
   localparam logic [8:0]    YM1         = 9'(Y_LINES - 1);

   typedef enum logic [3:0] {
      IDLE, HWRST, HWIDLE, SWRST, BUSY1, SETTLE, CMD, PIX, UPD, BUSY2, SLEEP, DONE
   } state_t;

   typedef enum logic [1:0] {S_GAP, S_SEND, S_HOLD, S_DRAIN} sub_t;

   state_t        state;
   sub_t          sub;
   logic          gap;
   logic [DW-1:0] cnt;
   logic [4:0]    idx;
   logic [PW-1:0] p;
   logic [2:0]    mode_q;

   logic [7:0]    cur_byte;
   logic          cur_first;
   logic          cur_last;
   logic          host_pix;

   assign host_pix  = (state == PIX) && (mode_q[1:0] == 2'd3);
   assign pix_ready = host_pix && (sub == S_SEND) && !spi_wait && !spi_we;

   // Byte table: what the current (state, idx, p) position sends and where its group ends.
   always_comb begin
      cur_byte  = 8'h00;
      cur_first = 1'b0;
      cur_last  = 1'b0;
      case (state)
         SWRST: begin cur_byte = 8'h12; cur_first = 1'b1; cur_last = 1'b1; end
         CMD: begin
            case (idx)
               5'd0:    begin cur_byte = 8'h11; cur_first = 1'b1; end
               5'd1:    begin cur_byte = 8'h03; cur_last  = 1'b1; end
               5'd2:    begin cur_byte = 8'h3C; cur_first = 1'b1; end
               5'd3:    begin cur_byte = 8'h05; cur_last  = 1'b1; end
               5'd4:    begin cur_byte = 8'h44; cur_first = 1'b1; end
               5'd5:    cur_byte = 8'h00;
               5'd6:    begin cur_byte = XM1;   cur_last  = 1'b1; end
               5'd7:    begin cur_byte = 8'h45; cur_first = 1'b1; end
               5'd8:    cur_byte = 8'h00;
               5'd9:    cur_byte = 8'h00;
               5'd10:   cur_byte = YM1[7:0];
               5'd11:   begin cur_byte = {7'd0, YM1[8]}; cur_last = 1'b1; end
               5'd12:   begin cur_byte = 8'h4E; cur_first = 1'b1; end
               5'd13:   begin cur_byte = 8'h00; cur_last  = 1'b1; end
               5'd14:   begin cur_byte = 8'h4F; cur_first = 1'b1; end
               5'd15:   cur_byte = 8'h00;
               5'd16:   begin cur_byte = 8'h00; cur_last  = 1'b1; end
               default: begin cur_byte = 8'h24; cur_first = 1'b1; end
            endcase
         end
         PIX: begin
            cur_last = (p == P_LAST);
            case (mode_q[1:0])
               2'd0:    cur_byte = 8'h00;
               2'd1:    cur_byte = 8'hFF;
               2'd2:    cur_byte = p[STRIPE_BIT] ? 8'hFF : 8'h00;
               default: cur_byte = pix_data;
            endcase
         end
         UPD: begin
            case (idx)
               5'd0:    begin cur_byte = 8'h22; cur_first = 1'b1; end
               5'd1:    begin cur_byte = mode_q[2] ? 8'hFC : 8'hF4; cur_last = 1'b1; end
               default: begin cur_byte = 8'h20; cur_first = 1'b1; cur_last = 1'b1; end
            endcase
         end
         SLEEP: begin
            if (idx == 5'd0) begin cur_byte = 8'h10; cur_first = 1'b1; end
            else begin cur_byte = 8'h01; cur_last = 1'b1; end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sub        <= S_GAP;
         gap        <= 1'b0;
         cnt        <= '0;
         idx        <= '0;
         p          <= '0;
         mode_q     <= '0;
         spi_data   <= 8'h00;
         spi_we     <= 1'b0;
         spi_stream <= 1'b0;
         dc         <= 1'b1;
         epd_resetb <= 1'b1;
         active     <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mode_q     <= mode;
                  error      <= 1'b0;
                  active     <= 1'b1;
                  epd_resetb <= 1'b0;
                  cnt        <= '0;
                  state      <= HWRST;
               end
            end
            HWRST: begin
               if (cnt == RST_LAST) begin
                  epd_resetb <= 1'b1;
                  cnt        <= '0;
                  state      <= HWIDLE;
               end else cnt <= cnt + 1'b1;
            end
            HWIDLE: begin
               if (cnt == RST_LAST) begin
                  sub   <= S_GAP;
                  gap   <= 1'b0;
                  state <= SWRST;
               end else cnt <= cnt + 1'b1;
            end
            // Busy low on the entry cycle moves on at once; the counter only matters while busy stays high.
            BUSY1, BUSY2: begin
               if (!epd_busy) begin
                  cnt   <= '0;
                  idx   <= '0;
                  sub   <= S_GAP;
                  gap   <= 1'b0;
                  state <= (state == BUSY1) ? SETTLE : SLEEP;
               end else if (cnt == BUSY_LAST) begin
                  error      <= 1'b1;
                  spi_stream <= 1'b0;
                  dc         <= 1'b1;
                  active     <= 1'b0;
                  state      <= IDLE;
               end else cnt <= cnt + 1'b1;
            end
            SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  idx   <= '0;
                  sub   <= S_GAP;
                  gap   <= 1'b0;
                  state <= CMD;
               end else cnt <= cnt + 1'b1;
            end
            DONE: state <= IDLE;
            default: begin
               case (sub)
                  // Two idle cycles with stream low, then stream rises a cycle ahead of spi_we.
                  S_GAP: begin
                     if (gap) begin
                        spi_stream <= 1'b1;
                        sub        <= S_SEND;
                     end else gap <= 1'b1;
                  end
                  S_SEND: begin
                     if (!spi_wait && (!host_pix || pix_valid)) begin
                        spi_data <= cur_byte;
                        dc       <= ~cur_first;
                        spi_we   <= 1'b1;
                        sub      <= S_HOLD;
                     end
                  end
                  S_HOLD: begin
                     if (spi_wait) begin
                        spi_we <= 1'b0;
                        sub    <= S_DRAIN;
                     end
                  end
                  default: begin
                     if (!spi_wait) begin
                        if (cur_last) begin
                           spi_stream <= 1'b0;
                           sub        <= S_GAP;
                           gap        <= 1'b0;
                           case (state)
                              SWRST: begin cnt <= '0; state <= BUSY1; end
                              PIX:   begin idx <= '0; state <= UPD; end
                              UPD: begin
                                 if (idx == 5'd2) begin cnt <= '0; state <= BUSY2; end
                                 else idx <= idx + 5'd1;
                              end
                              SLEEP: begin
                                 done   <= 1'b1;
                                 active <= 1'b0;
                                 state  <= DONE;
                              end
                              default: idx <= idx + 5'd1;
                           endcase
                        end else begin
                           sub <= S_SEND;
                           if (state == CMD && idx == 5'd17) begin
                              p     <= '0;
                              state <= PIX;
                           end else if (state == PIX) p <= p + 1'b1;
                           else idx <= idx + 5'd1;
                        end
                     end
                  end
               endcase
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eink_seq_ctrl.sv
// Directed bench for eink_seq_ctrl: small panel geometry, a 3-cycle SPI master model and a byte log.
module tb_eink_seq_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic [2:0] mode;
   logic [7:0] pix_data;
   logic       pix_valid;
   logic       pix_ready;
   logic [7:0] spi_data;
   logic       spi_we;
   logic       spi_wait;
   logic       spi_stream;
   logic       dc;
   logic       epd_resetb;
   logic       epd_busy;
   logic       active;
   logic       done;
   logic       error;

   int vectors    = 0;
   int miscompares = 0;

   logic [7:0] log_b  [$];
   logic       log_dc [$];
   int         done_cnt    = 0;
   int         rstlow_cnt  = 0;
   int         gap_err     = 0;
   int         stab_err    = 0;
   int         stall_err   = 0;
   int         low_run     = 100;
   logic       prev_stream = 1'b0;
   logic       prev2_stream = 1'b0;
   logic [7:0] held_data   = 8'h00;
   logic       held_dc     = 1'b1;
   logic       in_stall    = 1'b0;
   int         wcnt        = 0;

   logic [7:0] hdr [19] = '{8'h12, 8'h11, 8'h03, 8'h3C, 8'h05, 8'h44, 8'h00, 8'h01,
                            8'h45, 8'h00, 8'h00, 8'h03, 8'h00, 8'h4E, 8'h00, 8'h4F,
                            8'h00, 8'h00, 8'h24};

   eink_seq_ctrl #(
      .X_BYTES(2), .Y_LINES(4), .RST_CYCLES(4), .SETTLE_CYCLES(3),
      .BUSY_TIMEOUT(50), .STRIPE_BIT(2)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .spi_data(spi_data), .spi_we(spi_we), .spi_wait(spi_wait), .spi_stream(spi_stream),
      .dc(dc), .epd_resetb(epd_resetb), .epd_busy(epd_busy),
      .active(active), .done(done), .error(error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // SPI master model: accepts a write and stays busy for 3 cycles.
   always @(posedge clk) begin
      if (rst) begin
         spi_wait <= 1'b0;
         wcnt     <= 0;
      end else if (spi_wait) begin
         if (wcnt == 1) spi_wait <= 1'b0;
         wcnt <= wcnt - 1;
      end else if (spi_we) begin
         spi_wait <= 1'b1;
         wcnt     <= 3;
      end
   end

   // Monitor: byte log plus group-framing and stability bookkeeping.
   always @(negedge clk) begin
      if (!epd_resetb) rstlow_cnt++;
      if (done) done_cnt++;
      if (spi_we && !spi_wait) begin
         log_b.push_back(spi_data);
         log_dc.push_back(dc);
         if (!spi_stream) gap_err++;
         if (!dc && !(prev_stream && !prev2_stream)) gap_err++;
         if (in_stall) stall_err++;
         held_data = spi_data;
         held_dc   = dc;
      end
      if (spi_wait && (spi_data !== held_data || dc !== held_dc)) stab_err++;
      if (spi_stream && !prev_stream && low_run < 2) gap_err++;
      low_run      = spi_stream ? 0 : low_run + 1;
      prev2_stream = prev_stream;
      prev_stream  = spi_stream;
   end

   task automatic start_frame(input logic [2:0] m);
      log_b.delete();
      log_dc.delete();
      done_cnt   = 0;
      rstlow_cnt = 0;
      mode  = m;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (done_cnt == 0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (done_cnt == 0) begin
         miscompares++;
         $display("[TB] FAIL %s done_wait: got no done pulse, want one within 4000 cycles", tag);
      end
      repeat (5) @(negedge clk);
      vectors++;
      if (active !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL %s active_after_done: got %b, want 0", tag, active);
      end
   endtask

   task automatic check_frame(input string tag, input logic [63:0] pix, input logic [7:0] upd);
      logic [7:0] exp_b;
      logic       exp_dc;
      logic [7:0] tl [5];
      int n;
      tl[0] = 8'h22; tl[1] = upd; tl[2] = 8'h20; tl[3] = 8'h10; tl[4] = 8'h01;
      n = log_b.size();
      vectors++;
      if (n !== 32) begin
         miscompares++;
         $display("[TB] FAIL %s byte_count: got %0d, want 32", tag, n);
      end
      for (int i = 0; i < 32 && i < n; i++) begin
         if (i < 19) exp_b = hdr[i];
         else if (i < 27) exp_b = pix[8*(i-19) +: 8];
         else exp_b = tl[i-27];
         exp_dc = !(i inside {0, 1, 3, 5, 8, 13, 15, 18, 27, 29, 30});
         vectors++;
         if (log_b[i] !== exp_b) begin
            miscompares++;
            $display("[TB] FAIL %s byte[%0d]: got %h, want %h", tag, i, log_b[i], exp_b);
         end
         vectors++;
         if (log_dc[i] !== exp_dc) begin
            miscompares++;
            $display("[TB] FAIL %s dc[%0d]: got %b, want %b", tag, i, log_dc[i], exp_dc);
         end
      end
      vectors++;
      if (rstlow_cnt !== 4) begin
         miscompares++;
         $display("[TB] FAIL %s resetb_low_cycles: got %0d, want 4", tag, rstlow_cnt);
      end
      vectors++;
      if (done_cnt !== 1) begin
         miscompares++;
         $display("[TB] FAIL %s done_pulses: got %0d, want 1", tag, done_cnt);
      end
      vectors++;
      if (gap_err !== 0) begin
         miscompares++;
         $display("[TB] FAIL %s group_framing: got %0d violations, want 0", tag, gap_err);
      end
      vectors++;
      if (stab_err !== 0) begin
         miscompares++;
         $display("[TB] FAIL %s data_stable_during_wait: got %0d violations, want 0", tag, stab_err);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      logic [15:0] got;
      got = {spi_we, spi_stream, dc, epd_resetb, pix_ready, active, done, error, spi_data};
      vectors++;
      if (got !== 16'h3000) begin
         miscompares++;
         $display("[TB] FAIL %s outputs{we,stream,dc,resetb,ready,active,done,error,data}: got %h, want 3000",
                  tag, got);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_idle_outputs("post_reset_idle");
   endtask

   task automatic test_full_frame;
      start_frame(3'd1);
      vectors++;
      if (active !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL full active_after_start: got %b, want 1", active);
      end
      wait_done("full");
      check_frame("full", 64'hFFFF_FFFF_FFFF_FFFF, 8'hF4);
   endtask

   task automatic test_stripes;
      start_frame(3'd2);
      wait_done("stripes");
      check_frame("stripes", 64'hFFFF_FFFF_0000_0000, 8'hF4);
   endtask

   task automatic test_host_stream;
      logic [63:0] hb;
      int n;
      hb = 64'h7856_3412_FF00_3CA5;
      stall_err = 0;
      start_frame(3'd7);
      for (int i = 0; i < 8; i++) begin
         pix_data  = hb[8*i +: 8];
         pix_valid = 1'b1;
         n = 0;
         while (!pix_ready && n < 2000) begin
            @(negedge clk);
            n++;
         end
         if (n >= 2000) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL host pix_ready_wait: got no pix_ready for byte %0d, want ready", i);
         end
         @(negedge clk);
         pix_valid = 1'b0;
         if (i == 3) begin
            #1;
            in_stall = 1'b1;
            repeat (20) @(negedge clk);
            in_stall = 1'b0;
         end
      end
      wait_done("host");
      vectors++;
      if (stall_err !== 0) begin
         miscompares++;
         $display("[TB] FAIL host bytes_during_stall: got %0d, want 0", stall_err);
      end
      check_frame("host", hb, 8'hFC);
   endtask

   task automatic test_timeout;
      int n;
      epd_busy = 1'b1;
      start_frame(3'd1);
      n = 0;
      while (!(log_b.size() >= 1 && !spi_stream) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (n >= 1000) begin
         miscompares++;
         $display("[TB] FAIL timeout busy1_entry: got no close of 0x12 group, want close");
      end
      vectors++;
      if (error !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL timeout error_at_entry: got %b, want 0", error);
      end
      repeat (49) @(negedge clk);
      vectors++;
      if (error !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL timeout error_at_49: got %b, want 0", error);
      end
      @(negedge clk);
      vectors++;
      if (error !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL timeout error_at_50: got %b, want 1", error);
      end
      vectors++;
      if ({active, spi_stream, dc} !== 3'b001) begin
         miscompares++;
         $display("[TB] FAIL timeout {active,stream,dc}: got %b, want 001", {active, spi_stream, dc});
      end
      repeat (10) @(negedge clk);
      vectors++;
      if (done_cnt !== 0 || log_b.size() !== 1) begin
         miscompares++;
         $display("[TB] FAIL timeout no_done_no_bytes: got done=%0d bytes=%0d, want 0 and 1",
                  done_cnt, log_b.size());
      end
      epd_busy = 1'b0;
      start_frame(3'd1);
      vectors++;
      if (error !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL timeout error_cleared_by_start: got %b, want 0", error);
      end
      wait_done("after_timeout");
      check_frame("after_timeout", 64'hFFFF_FFFF_FFFF_FFFF, 8'hF4);
   endtask

   task automatic test_start_while_active;
      start_frame(3'd1);
      repeat (30) @(negedge clk);
      mode  = 3'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("busy_start");
      check_frame("busy_start", 64'hFFFF_FFFF_FFFF_FFFF, 8'hF4);
      repeat (30) @(negedge clk);
      vectors++;
      if (active !== 1'b0 || log_b.size() !== 32) begin
         miscompares++;
         $display("[TB] FAIL busy_start no_second_frame: got active=%b bytes=%0d, want 0 and 32",
                  active, log_b.size());
      end
   endtask

   task automatic test_reset_mid_pixel;
      int n;
      start_frame(3'd1);
      n = 0;
      while (log_b.size() < 21 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (n >= 2000) begin
         miscompares++;
         $display("[TB] FAIL mid_reset reach_pixels: got %0d bytes, want 21", log_b.size());
      end
      rst = 1'b1;
      @(negedge clk);
      check_idle_outputs("mid_reset");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      start_frame(3'd0);
      wait_done("white");
      check_frame("white", 64'h0, 8'hF4);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      mode      = 3'd0;
      pix_data  = 8'h00;
      pix_valid = 1'b0;
      epd_busy  = 1'b0;
      @(negedge clk);
      test_reset;
      test_full_frame;
      test_stripes;
      test_host_stream;
      test_timeout;
      test_start_while_active;
      test_reset_mid_pixel;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
